// File: rtl/hex_scroll_pkg.sv
// hex_scroll_pkg
// Shared definitions for the HEX scroll controller:
//   - scroll_state_t : scroll FSM state encoding (IDLE / SCROLL / HOLD)
//   - BLANK_CODE_DEFAULT : character code that renders as an empty digit
//   - wrap_idx : index add modulo a power-of-two buffer length
package hex_scroll_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCROLL = 2'd1,
    HOLD   = 2'd2
  } scroll_state_t;

  localparam logic [3:0] BLANK_CODE_DEFAULT = 4'hF;

  // len is a power of two, so masking is the modulo.
  function automatic int unsigned wrap_idx(int unsigned base, int unsigned off,
                                           int unsigned len);
    return (base + off) & (len - 1);
  endfunction

endpackage

// File: rtl/hex_scroll_ctrl_tick.sv
// hex_tick_gen
// Scroll-rate prescaler. Counts 0..TICK_DIV-1 while en is high and raises
// tick for the single cycle in which the count equals TICK_DIV-1; the count
// then wraps to 0. Whenever en is low the counter is held at 0.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : count enable
//   tick       : one-cycle scroll tick
module hex_tick_gen #(
  parameter int TICK_DIV = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/hex_scroll_ctrl.sv
// hex_scroll_ctrl
// Scrolls an MSG_LEN-entry buffer of 4-bit character codes across four
// seven-segment decoders, one position per tick. After the last position
// the final window is held for HOLD_TICKS ticks, then done pulses and the
// display blanks.
// Build option: define HEX_SCROLL_BLINK_EN to blink the window during HOLD
// (message / blank alternating per tick, message first).
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, stop       : one-cycle pulses; stop wins when both are high
//   wr_en/addr/data   : message buffer write port (accepted only in IDLE)
//   wr_err            : one-cycle pulse when a write arrives while busy
//   busy              : high in SCROLL or HOLD
//   done              : one-cycle pulse on normal completion
//   pos               : current scroll position
//   code3..code0      : codes for HEX3 (leftmost) .. HEX0 (rightmost)
// Handshake: start/stop/wr_en are single-cycle strobes sampled on the rising
// clock edge; there is no ready, a strobe is either acted on or dropped
// (wr_err flags dropped writes).
module hex_scroll_ctrl
  import hex_scroll_pkg::*;
#(
  parameter int         TICK_DIV   = 25000000,
  parameter int         MSG_LEN    = 8,
  parameter int         HOLD_TICKS = 4,
  parameter logic [3:0] BLANK_CODE = BLANK_CODE_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       wr_en,
  input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
  input  logic [3:0]                 wr_data,
  output logic                       wr_err,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(MSG_LEN)-1:0] pos,
  output logic [3:0]                 code3,
  output logic [3:0]                 code2,
  output logic [3:0]                 code1,
  output logic [3:0]                 code0
);

  localparam int AW = $clog2(MSG_LEN);
  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [AW-1:0] POS_LAST  = AW'(MSG_LEN - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

  scroll_state_t state, next_state;
  logic          tick;
  logic [3:0]    msg [MSG_LEN];
  logic [HW-1:0] hold_cnt;
  logic          hold_done;
  logic [3:0]    win3, win2, win1, win0;

  hex_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (busy),
    .tick (tick)
  );

  assign hold_done = (state == HOLD) && tick && (hold_cnt == HOLD_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start && !stop) next_state = SCROLL;
      SCROLL:  if (stop) next_state = IDLE;
               else if (tick && pos == POS_LAST) next_state = HOLD;
      HOLD:    if (stop || hold_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state == SCROLL) || (state == HOLD);
  end

  // Message buffer: writable only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MSG_LEN; i++) msg[i] <= BLANK_CODE;
    end else if (wr_en && state == IDLE) begin
      msg[wr_addr] <= wr_data;
    end
  end

  // Position, hold counter and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos      <= '0;
      hold_cnt <= '0;
      done     <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      wr_err <= wr_en && busy;
      done   <= hold_done && !stop;
      if (state == IDLE || next_state == IDLE) begin
        pos <= '0;
      end else if (state == SCROLL && tick && pos != POS_LAST) begin
        pos <= pos + 1'b1;
      end
      if (state != HOLD)  hold_cnt <= '0;
      else if (tick)      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  assign win3 = msg[pos];
  assign win2 = msg[AW'(wrap_idx(32'(pos), 1, MSG_LEN))];
  assign win1 = msg[AW'(wrap_idx(32'(pos), 2, MSG_LEN))];
  assign win0 = msg[AW'(wrap_idx(32'(pos), 3, MSG_LEN))];

`ifdef HEX_SCROLL_BLINK_EN
  // show_msg selects message (1) or blank (0) for the next HOLD window.
  logic show_msg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    show_msg <= 1'b1;
    else if (state != HOLD)        show_msg <= 1'b1;
    else if (tick)                 show_msg <= ~show_msg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {code3, code2, code1, code0} <= {4{BLANK_CODE}};
    end else if (hold_done && !stop) begin
      // Final hold tick: message stays up one cycle before IDLE blanks it.
      {code3, code2, code1, code0} <= {win3, win2, win1, win0};
    end else if (next_state == IDLE) begin
      {code3, code2, code1, code0} <= {4{BLANK_CODE}};
    end else if (state == SCROLL) begin
      {code3, code2, code1, code0} <= {win3, win2, win1, win0};
    end else if (state == HOLD) begin
      {code3, code2, code1, code0} <= show_msg ? {win3, win2, win1, win0}
                                               : {4{BLANK_CODE}};
    end
  end
`else
  // Window lags pos by one cycle; HOLD keeps the last registered window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {code3, code2, code1, code0} <= {4{BLANK_CODE}};
    end else if (next_state == IDLE) begin
      {code3, code2, code1, code0} <= {4{BLANK_CODE}};
    end else if (state == SCROLL) begin
      {code3, code2, code1, code0} <= {win3, win2, win1, win0};
    end
  end
`endif

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// tb_hex_scroll_ctrl
// Self-checking bench for hex_scroll_ctrl (default build) with TICK_DIV=4,
// MSG_LEN=8, HOLD_TICKS=2. Expected outputs come from a timeline model of a
// scroll pass: k cycles after start is taken, pos = min(k/TICK_DIV, MSG_LEN-1)
// until completion at k = TICK_DIV*(MSG_LEN+HOLD_TICKS), codes show the
// window of the previous cycle's position.
module tb_hex_scroll_ctrl;

  localparam int TICK_DIV   = 4;
  localparam int MSG_LEN    = 8;
  localparam int HOLD_TICKS = 2;
  localparam int AW         = 3;
  localparam logic [3:0] BLANK = 4'hF;
  localparam int DONE_K     = TICK_DIV * (MSG_LEN + HOLD_TICKS);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, stop = 1'b0, wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [3:0]    wr_data = '0;
  logic          wr_err, busy, done;
  logic [AW-1:0] pos;
  logic [3:0]    code3, code2, code1, code0;

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] ref_msg [MSG_LEN];

  hex_scroll_ctrl #(
    .TICK_DIV(TICK_DIV), .MSG_LEN(MSG_LEN), .HOLD_TICKS(HOLD_TICKS), .BLANK_CODE(BLANK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
    .busy(busy), .done(done), .pos(pos),
    .code3(code3), .code2(code2), .code1(code1), .code0(code0)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference model
  function automatic int exp_pos(int k);
    int p;
    if (k >= DONE_K) return 0;
    p = k / TICK_DIV;
    if (p > MSG_LEN - 1) p = MSG_LEN - 1;
    return p;
  endfunction

  function automatic logic [15:0] exp_codes(int k);
    int p;
    if (k == 0 || k >= DONE_K) return {4{BLANK}};
    p = exp_pos(k - 1);
    return {ref_msg[p], ref_msg[(p + 1) % MSG_LEN],
            ref_msg[(p + 2) % MSG_LEN], ref_msg[(p + 3) % MSG_LEN]};
  endfunction

  // Driver tasks
  task automatic write_msg(input logic [3:0] vals [MSG_LEN]);
    for (int i = 0; i < MSG_LEN; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = vals[i];
      ref_msg[i] = vals[i];
      @(posedge clk); #1;
      wr_en = 1'b0;
      n_checks++;
      if (wr_err !== 1'b0) $display("FAIL idle_write wr_err got %b exp 0", wr_err);
      else n_pass++;
    end
  endtask

  // Starts a pass and checks every cycle against the model. stop_k / wr_k
  // inject a stop or a write after cycle k (-1 = none); noisy adds one
  // start pulse while busy, which must be ignored.
  task automatic run_pass(input string tag, input int stop_k, input int wr_k, input bit noisy);
    int noise_k, last_k, e_pos;
    logic e_busy, e_done, e_err;
    logic [15:0] e_codes;
    noise_k = noisy ? int'($urandom_range(1, DONE_K - 2)) : -1;
    last_k  = (stop_k >= 0) ? stop_k + 3 : DONE_K + 2;
    start = 1'b1;
    for (int k = 0; k <= last_k; k++) begin
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0; wr_en = 1'b0;
      if (stop_k >= 0 && k > stop_k) begin
        e_pos = 0; e_busy = 1'b0; e_done = 1'b0; e_codes = {4{BLANK}};
      end else begin
        e_pos = exp_pos(k); e_busy = (k < DONE_K); e_done = (k == DONE_K);
        e_codes = exp_codes(k);
      end
      e_err = (wr_k >= 0 && k == wr_k + 1);
      n_checks += 5;
      if (pos !== AW'(e_pos)) $display("FAIL %s k=%0d pos got %0d exp %0d", tag, k, pos, e_pos);
      else n_pass++;
      if (busy !== e_busy) $display("FAIL %s k=%0d busy got %b exp %b", tag, k, busy, e_busy);
      else n_pass++;
      if (done !== e_done) $display("FAIL %s k=%0d done got %b exp %b", tag, k, done, e_done);
      else n_pass++;
      if (wr_err !== e_err) $display("FAIL %s k=%0d wr_err got %b exp %b", tag, k, wr_err, e_err);
      else n_pass++;
      if ({code3, code2, code1, code0} !== e_codes)
        $display("FAIL %s k=%0d codes got %h exp %h", tag, k, {code3, code2, code1, code0}, e_codes);
      else n_pass++;
      if (k == stop_k) stop = 1'b1;
      if (k == wr_k) begin wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'hA; end
      if (k == noise_k) start = 1'b1;
    end
    start = 1'b0; stop = 1'b0; wr_en = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < MSG_LEN; i++) ref_msg[i] = BLANK;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      n_checks += 4;
      if ({code3, code2, code1, code0} !== {4{BLANK}})
        $display("FAIL reset c=%0d codes got %h exp ffff", c, {code3, code2, code1, code0});
      else n_pass++;
      if (busy !== 1'b0) $display("FAIL reset c=%0d busy got %b exp 0", c, busy); else n_pass++;
      if (pos !== '0) $display("FAIL reset c=%0d pos got %0d exp 0", c, pos); else n_pass++;
      if (done !== 1'b0 || wr_err !== 1'b0)
        $display("FAIL reset c=%0d done/wr_err got %b%b exp 00", c, done, wr_err);
      else n_pass++;
    end
  endtask

  task automatic test_full_scroll();
    logic [3:0] vals [MSG_LEN];
    for (int i = 0; i < MSG_LEN; i++) vals[i] = 4'(i);
    write_msg(vals);
    run_pass("scroll_seq", -1, -1, 1'b0);
    for (int i = 0; i < MSG_LEN; i++) vals[i] = 4'($urandom_range(0, 15));
    write_msg(vals);
    // Write in the same cycle as start: the first window must see it.
    wr_en = 1'b1; wr_addr = AW'($urandom_range(0, 3)); wr_data = 4'($urandom_range(0, 14));
    ref_msg[wr_addr] = wr_data;
    run_pass("scroll_rand", -1, -1, 1'b0);
  endtask

  task automatic test_stop();
    run_pass("stop_pos3", 3 * TICK_DIV, -1, 1'b0);
    run_pass("stop_rand", int'($urandom_range(1, DONE_K - 2)), -1, 1'b0);
  endtask

  task automatic test_write_busy();
    logic [3:0] vals [MSG_LEN];
    for (int i = 0; i < MSG_LEN; i++) vals[i] = 4'(i);
    write_msg(vals);
    run_pass("wr_busy", -1, TICK_DIV, 1'b0);
    run_pass("wr_busy_after", -1, -1, 1'b0);
  endtask

  task automatic test_start_stop();
    start = 1'b1; stop = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0;
      n_checks += 2;
      if (busy !== 1'b0) $display("FAIL start_stop c=%0d busy got %b exp 0", c, busy); else n_pass++;
      if (pos !== '0) $display("FAIL start_stop c=%0d pos got %0d exp 0", c, pos); else n_pass++;
    end
    run_pass("start_busy", -1, -1, 1'b1);
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    for (int k = 0; k < DONE_K - TICK_DIV - 2; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    n_checks++;
    if (pos !== AW'(MSG_LEN - 1)) $display("FAIL areset_pre pos got %0d exp %0d", pos, MSG_LEN - 1);
    else n_pass++;
    rst_n = 1'b0;
    #2;
    n_checks += 3;
    if ({code3, code2, code1, code0} !== {4{BLANK}})
      $display("FAIL areset codes got %h exp ffff", {code3, code2, code1, code0});
    else n_pass++;
    if (busy !== 1'b0) $display("FAIL areset busy got %b exp 0", busy); else n_pass++;
    if (pos !== '0 || done !== 1'b0) $display("FAIL areset pos/done got %0d/%b exp 0/0", pos, done);
    else n_pass++;
    #3 rst_n = 1'b1;
    for (int i = 0; i < MSG_LEN; i++) ref_msg[i] = BLANK;
    run_pass("post_reset", -1, -1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_full_scroll();
    test_stop();
    test_write_busy();
    test_start_stop();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
